sgpr_busy_table: RTL and testbench
==================================

# sgpr_busy_table

Scoreboard for scalar registers in the issue stage. It holds one busy bit per SGPR. Bits are set when an instruction that writes SGPRs issues, and cleared when the SALU or LSU writes the result back. Each cycle it answers a registered hazard query covering an instruction's two source ranges and one destination range. Range-to-bit expansion uses the same 4-word, wrap-around decode that the issue stage already uses for SGPR masks.

## Interface
- NUM_SGPR, 104, number of scalar registers tracked
- ADDR_W, 9, SGPR address width
- CNT_W, 7, width of busy_count (must hold NUM_SGPR)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- set_valid / set_addr / set_mask  in  1 / ADDR_W / 4  issue-side range to mark busy
- clr0_valid / clr0_addr / clr0_mask  in  1 / ADDR_W / 4  SALU writeback range to clear
- clr1_valid / clr1_addr / clr1_mask  in  1 / ADDR_W / 4  LSU writeback range to clear
- flush  in  1  clear entire table (wavefront halt/kill)
- chk_valid  in  1  hazard query strobe
- chk_s0_addr, chk_s0_mask, chk_s1_addr, chk_s1_mask, chk_d_addr, chk_d_mask  in  ADDR_W / 4 each  query ranges
- chk_done  out  1  query result valid
- chk_busy  out  1  any queried register busy
- busy_vector  out  NUM_SGPR  current table
- busy_count  out  CNT_W  population count of busy_vector
- err_clr_idle  out  1  sticky: clear targeted a non-busy register

## Operation
- Range decode: for a range (addr, mask), bit i of mask selects register addr+i, for i = 0..3.
  - If addr+i >= NUM_SGPR, the selected register is addr+i-NUM_SGPR (wraps into bits 0..3).
  - addr < NUM_SGPR is a caller obligation.
  - A zero mask, or a deasserted valid, is a no-op.
- Table update at each clk edge: next = (table & ~clr0m & ~clr1m) | setm.
  - Set wins over any same-cycle clear of the same bit.
  - Both clear ports may hit the same bit in the same cycle; this is legal.
- flush: next = 0 and err_clr_idle is unaffected. It overrides set and clear in the same cycle.
- err_clr_idle sets when a valid clear selects a bit that is 0 in table and is not also selected by a same-cycle set. It clears only on rst.
- Query evaluation:
  - The union of the three ranges is checked against (table | setm), so a same-cycle issue blocks dependents.
  - Same-cycle clears are ignored; the result is conservative.
  - flush in the query cycle does not alter the result.
- busy_count is the popcount of the registered table (busy_vector), registered together with it.

## Timing
- rst: table = 0, busy_vector = 0, busy_count = 0, chk_done = 0, chk_busy = 0, err_clr_idle = 0.
- Set, clear and flush take effect in busy_vector/busy_count one cycle after the strobe edge.
- Query latency is 1 cycle.
  - chk_done is registered from chk_valid.
  - chk_busy is registered from the evaluation and holds its value while chk_done = 0.
- One query per cycle, fully pipelined; back-to-back queries are legal with no bubbles.
- No backpressure: the caller must sample chk_done in the cycle it is high.
- rst asserted mid-operation aborts an in-flight query (chk_done = 0 next cycle) and empties the table immediately, asynchronously.

## Test plan
- Reset, then set (addr 10, mask 4'b0011) -> next cycle busy_vector bits 10,11 = 1, busy_count = 2.
- Wrap-around:
  - Set (addr 102, mask 4'b1111) -> bits 102, 103, 0, 1 busy, busy_count = 4.
  - Clear via clr1 with the same range -> busy_count = 0, err_clr_idle = 0.
- Set/clear collision:
  - Bit 20 busy; same cycle set (20, 4'b0001) and clr0 (20, 4'b0001) -> bit 20 remains 1.
  - Then clr0 and clr1 both on 20 -> bit 20 = 0, no error.
- Query bypass:
  - Table empty; same cycle set (30, 4'b0001) and query s0 = (30, 4'b0001) -> next cycle chk_done = 1, chk_busy = 1.
  - Query s1 = (31, 4'b0001) -> chk_busy = 0.
- Idle clear: clr0 (50, 4'b0001) on empty table -> err_clr_idle = 1 and stays 1 until rst.
- Flush priority and mid-op reset:
  - Flush with simultaneous set (5, 4'b0001) -> busy_vector = 0.
  - Assert rst the cycle after chk_valid -> chk_done = 0, outputs at reset values.

Source files
------------

// File: rtl/sgpr_busy_table.sv
// sgpr_busy_table: one busy bit per scalar register for the issue stage.
// Ranges of up to four registers are set on issue and cleared on SALU/LSU
// writeback; a registered hazard query checks two source ranges and one
// destination range against the table (bypassing same-cycle sets).
module sgpr_busy_table #(
    parameter int unsigned NUM_SGPR = 104,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned CNT_W    = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_valid,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic [3:0]          set_mask,
    input  logic                clr0_valid,
    input  logic [ADDR_W-1:0]   clr0_addr,
    input  logic [3:0]          clr0_mask,
    input  logic                clr1_valid,
    input  logic [ADDR_W-1:0]   clr1_addr,
    input  logic [3:0]          clr1_mask,
    input  logic                flush,
    input  logic                chk_valid,
    input  logic [ADDR_W-1:0]   chk_s0_addr,
    input  logic [3:0]          chk_s0_mask,
    input  logic [ADDR_W-1:0]   chk_s1_addr,
    input  logic [3:0]          chk_s1_mask,
    input  logic [ADDR_W-1:0]   chk_d_addr,
    input  logic [3:0]          chk_d_mask,
    output logic                chk_done,
    output logic                chk_busy,
    output logic [NUM_SGPR-1:0] busy_vector,
    output logic [CNT_W-1:0]    busy_count,
    output logic                err_clr_idle
);

    // Expand (addr, mask) into a register bitmap; addr+i past the top wraps to the bottom.
    function automatic logic [NUM_SGPR-1:0] range_mask(
        input logic              valid,
        input logic [ADDR_W-1:0] addr,
        input logic [3:0]        mask
    );
        logic [NUM_SGPR-1:0] m;
        int unsigned         idx;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = 32'(addr) + i;
            if (idx >= NUM_SGPR) idx = idx - NUM_SGPR;
            if (valid && mask[i[1:0]]) m = m | (NUM_SGPR'(1) << idx);
        end
        return m;
    endfunction

    logic [NUM_SGPR-1:0] table_q, table_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [NUM_SGPR-1:0] set_m, clr0_m, clr1_m, chk_m;

    // Decode all incoming ranges.
    always_comb begin
        set_m  = range_mask(set_valid, set_addr, set_mask);
        clr0_m = range_mask(clr0_valid, clr0_addr, clr0_mask);
        clr1_m = range_mask(clr1_valid, clr1_addr, clr1_mask);
        chk_m  = range_mask(1'b1, chk_s0_addr, chk_s0_mask)
               | range_mask(1'b1, chk_s1_addr, chk_s1_mask)
               | range_mask(1'b1, chk_d_addr, chk_d_mask);
    end

    // Next table state, error flag and count; flush beats set and clear.
    always_comb begin
        table_d = '0;
        err_d   = err_q;
        if (!flush) begin
            table_d = (table_q & ~clr0_m & ~clr1_m) | set_m;
            // A clear of a bit that is idle and not being set this cycle is an error.
            if (|((clr0_m | clr1_m) & ~table_q & ~set_m)) err_d = 1'b1;
        end
        count_d = CNT_W'($countones(table_d));
    end

    // Query evaluation: same-cycle sets count as busy, same-cycle clears are ignored.
    always_comb begin
        done_d = chk_valid;
        busy_d = busy_q;
        if (chk_valid) busy_d = |(chk_m & (table_q | set_m));
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            table_q <= table_d;
            count_q <= count_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_vector  = table_q;
    assign busy_count   = count_q;
    assign err_clr_idle = err_q;
    assign chk_done     = done_q;
    assign chk_busy     = busy_q;

endmodule

// File: tb/tb_sgpr_busy_table.sv
// Testbench for sgpr_busy_table: directed vector table, a hand-written
// mid-operation reset sequence, then randomized traffic against a model.
module tb_sgpr_busy_table;

    localparam int NS = 104;

    logic          clk, rst;
    logic          set_valid, clr0_valid, clr1_valid, flush, chk_valid;
    logic [8:0]    set_addr, clr0_addr, clr1_addr;
    logic [3:0]    set_mask, clr0_mask, clr1_mask;
    logic [8:0]    chk_s0_addr, chk_s1_addr, chk_d_addr;
    logic [3:0]    chk_s0_mask, chk_s1_mask, chk_d_mask;
    logic          chk_done, chk_busy, err_clr_idle;
    logic [NS-1:0] busy_vector;
    logic [6:0]    busy_count;

    int checks = 0;
    int errors = 0;

    sgpr_busy_table dut (
        .clk(clk), .rst(rst),
        .set_valid(set_valid), .set_addr(set_addr), .set_mask(set_mask),
        .clr0_valid(clr0_valid), .clr0_addr(clr0_addr), .clr0_mask(clr0_mask),
        .clr1_valid(clr1_valid), .clr1_addr(clr1_addr), .clr1_mask(clr1_mask),
        .flush(flush), .chk_valid(chk_valid),
        .chk_s0_addr(chk_s0_addr), .chk_s0_mask(chk_s0_mask),
        .chk_s1_addr(chk_s1_addr), .chk_s1_mask(chk_s1_mask),
        .chk_d_addr(chk_d_addr), .chk_d_mask(chk_d_mask),
        .chk_done(chk_done), .chk_busy(chk_busy),
        .busy_vector(busy_vector), .busy_count(busy_count),
        .err_clr_idle(err_clr_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sv, sa, sm, c0v, c0a, c0m, c1v, c1a, c1m, fl;
        int qv, q0a, q0m, q1a, q1m, qda, qdm;
        int pa, pb, cnt, done, busy, err;
    } vec_t;

    function automatic vec_t mk(
        int sv, int sa, int sm, int c0v, int c0a, int c0m, int c1v, int c1a, int c1m, int fl,
        int qv, int q0a, int q0m, int q1a, int q1m, int qda, int qdm,
        int pa, int pb, int cnt, int done, int busy, int err);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sm = sm; v.c0v = c0v; v.c0a = c0a; v.c0m = c0m;
        v.c1v = c1v; v.c1a = c1a; v.c1m = c1m; v.fl = fl;
        v.qv = qv; v.q0a = q0a; v.q0m = q0m; v.q1a = q1a; v.q1m = q1m;
        v.qda = qda; v.qdm = qdm;
        v.pa = pa; v.pb = pb; v.cnt = cnt; v.done = done; v.busy = busy; v.err = err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        set_valid = 1'(v.sv);   set_addr = 9'(v.sa);   set_mask = 4'(v.sm);
        clr0_valid = 1'(v.c0v); clr0_addr = 9'(v.c0a); clr0_mask = 4'(v.c0m);
        clr1_valid = 1'(v.c1v); clr1_addr = 9'(v.c1a); clr1_mask = 4'(v.c1m);
        flush = 1'(v.fl);       chk_valid = 1'(v.qv);
        chk_s0_addr = 9'(v.q0a); chk_s0_mask = 4'(v.q0m);
        chk_s1_addr = 9'(v.q1a); chk_s1_mask = 4'(v.q1m);
        chk_d_addr = 9'(v.qda);  chk_d_mask = 4'(v.qdm);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference model: per-register busy flags plus query/error state.
    bit mtab[NS];
    bit merr, mdone, mbusy;

    function automatic logic [NS-1:0] rmask(input int v, input int a, input int m);
        logic [NS-1:0] r;
        logic [6:0]    k;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (v != 0 && ((m >> i) & 1) != 0) begin
                k = 7'((a + i) % NS);
                r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NS; r++) mtab[r] = 1'b0;
        merr = 1'b0; mdone = 1'b0; mbusy = 1'b0;
    endtask

    task automatic model_step(input vec_t v);
        logic [NS-1:0] s, c, q;
        bit            hit;
        s = rmask(v.sv, v.sa, v.sm);
        c = rmask(v.c0v, v.c0a, v.c0m) | rmask(v.c1v, v.c1a, v.c1m);
        q = rmask(1, v.q0a, v.q0m) | rmask(1, v.q1a, v.q1m) | rmask(1, v.qda, v.qdm);
        hit = 1'b0;
        for (int r = 0; r < NS; r++) if (q[r] && (mtab[r] || s[r])) hit = 1'b1;
        mdone = (v.qv != 0);
        if (v.qv != 0) mbusy = hit;
        for (int r = 0; r < NS; r++) begin
            if (v.fl != 0) mtab[r] = 1'b0;
            else if (s[r]) mtab[r] = 1'b1;
            else if (c[r]) begin
                if (!mtab[r]) merr = 1'b1;
                mtab[r] = 1'b0;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic [NS-1:0] ev;
        int            n;
        n = 0;
        for (int r = 0; r < NS; r++) begin
            ev[r] = mtab[r];
            n += int'(mtab[r]);
        end
        checks++;
        if (busy_vector !== ev) begin
            errors++;
            $display("FAIL %s busy_vector actual=%h required=%h", tag, busy_vector, ev);
        end
        chk({tag, " busy_count"}, int'(busy_count), n);
        chk({tag, " chk_done"}, int'(chk_done), int'(mdone));
        chk({tag, " chk_busy"}, int'(chk_busy), int'(mbusy));
        chk({tag, " err_clr_idle"}, int'(err_clr_idle), int'(merr));
    endtask

    vec_t vecs[$];
    vec_t z;

    initial begin
        z = mk(0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,0, 0,0,0,0,0,0);
        drive(z);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy_vector", int'(|busy_vector), 0);
        chk("reset busy_count", int'(busy_count), 0);
        chk("reset chk_done", int'(chk_done), 0);
        chk("reset chk_busy", int'(chk_busy), 0);
        chk("reset err", int'(err_clr_idle), 0);
        rst = 1'b0;

        // sv sa sm | c0 | c1 | fl | qv q0 q1 qd | probe addr,bit | cnt done busy err
        vecs.push_back(mk(1,10,3, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,0, 10,1, 2,0,0,0));
        vecs.push_back(mk(1,102,15, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,0, 0,1, 6,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,102,15, 0, 0,0,0,0,0,0,0, 103,0, 2,0,0,0));
        vecs.push_back(mk(0,0,0, 1,10,3, 0,0,0, 0, 0,0,0,0,0,0,0, 11,0, 0,0,0,0));
        vecs.push_back(mk(1,20,1, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,0, 20,1, 1,0,0,0));
        vecs.push_back(mk(1,20,1, 1,20,1, 0,0,0, 0, 0,0,0,0,0,0,0, 20,1, 1,0,0,0));
        vecs.push_back(mk(0,0,0, 1,20,1, 1,20,1, 0, 0,0,0,0,0,0,0, 20,0, 0,0,0,0));
        vecs.push_back(mk(1,30,1, 0,0,0, 0,0,0, 0, 1,30,1,0,0,0,0, 30,1, 1,1,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0, 1,0,0,31,1,0,0, 31,0, 1,1,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,0, 30,1, 1,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0, 1,0,0,0,0,29,3, 29,0, 1,1,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,0, 30,1, 1,0,1,0));
        vecs.push_back(mk(0,0,0, 1,50,1, 0,0,0, 0, 0,0,0,0,0,0,0, 50,0, 1,0,1,1));
        vecs.push_back(mk(1,5,1, 0,0,0, 0,0,0, 1, 0,0,0,0,0,0,0, 5,0, 0,0,1,1));
        vecs.push_back(mk(1,0,1, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,0, 0,1, 1,0,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0, 1,103,2,0,0,0,0, 0,1, 1,1,1,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0, 1,103,1,100,14,0,0, 1,0, 1,1,0,1));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d busy_count", i), int'(busy_count), vecs[i].cnt);
            chk($sformatf("vec%0d chk_done", i), int'(chk_done), vecs[i].done);
            chk($sformatf("vec%0d chk_busy", i), int'(chk_busy), vecs[i].busy);
            chk($sformatf("vec%0d err", i), int'(err_clr_idle), vecs[i].err);
            chk($sformatf("vec%0d bit%0d", i, vecs[i].pa), int'(busy_vector[vecs[i].pa]),
                vecs[i].pb);
        end

        // Mid-operation reset: query in flight, rst raised between edges.
        drive(mk(1,40,1, 0,0,0, 0,0,0, 0, 1,40,1,0,0,0,0, 0,0,0,0,0,0));
        @(posedge clk);
        #1;
        chk("pre-rst bit40", int'(busy_vector[40]), 1);
        drive(mk(0,0,0, 0,0,0, 0,0,0, 0, 1,40,1,0,0,0,0, 0,0,0,0,0,0));
        #3;
        rst = 1'b1;
        #1;
        chk("async rst busy_vector", int'(|busy_vector), 0);
        chk("async rst busy_count", int'(busy_count), 0);
        chk("async rst chk_done", int'(chk_done), 0);
        chk("async rst chk_busy", int'(chk_busy), 0);
        chk("async rst err", int'(err_clr_idle), 0);
        @(posedge clk);
        #1;
        chk("rst hold chk_done", int'(chk_done), 0);
        drive(z);
        rst = 1'b0;
        model_reset();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v = z;
            v.sv = int'($urandom_range(0, 1));  v.sa = int'($urandom_range(0, NS-1));
            v.sm = int'($urandom_range(0, 15));
            v.fl = ($urandom_range(0, 31) == 0) ? 1 : 0;
            if (v.fl == 0) begin
                v.c0v = int'($urandom_range(0, 1)); v.c0a = int'($urandom_range(0, NS-1));
                v.c0m = int'($urandom_range(0, 15));
                v.c1v = int'($urandom_range(0, 1)); v.c1a = int'($urandom_range(0, NS-1));
                v.c1m = int'($urandom_range(0, 15));
            end
            v.qv = int'($urandom_range(0, 1));
            v.q0a = int'($urandom_range(0, NS-1)); v.q0m = int'($urandom_range(0, 15));
            v.q1a = int'($urandom_range(0, NS-1)); v.q1m = int'($urandom_range(0, 15));
            v.qda = int'($urandom_range(0, NS-1)); v.qdm = int'($urandom_range(0, 15));
            drive(v);
            model_step(v);
            @(posedge clk);
            #1;
            compare_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
